adc_readout: RTL

//   Host-side sequencer for the digital single-slope ADC controller: issues restart pulses at a

---
 rtl/adc_readout.sv | 117 +++++++++++
 1 files changed

// File: rtl/adc_readout.sv
// Sample sequencer for the single-slope ADC: paces restart pulses, captures counts
// into a small FIFO and streams them out on ready/valid with sticky error flags.
module adc_readout #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 300
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [15:0]      sample_period,
    output logic             restart,
    input  logic             adc_busy,
    input  logic             adc_valid,
    input  logic [WIDTH-1:0] adc_count,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             overflow,
    output logic             timeout_err,
    input  logic             clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, CONV, WAIT} state_t;

    state_t           state, state_nx;
    logic [15:0]      per_cnt;
    logic [TW-1:0]    to_cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      occ;
    logic             push, pop, full, do_write, ovf_evt, timeout_evt, period_due, conv_done;
    logic             busy_unused;

    // busy is informational; progress relies only on valid or the timeout
    assign busy_unused = adc_busy;

    // due one cycle early so the next restart lands exactly sample_period after the last
    assign period_due  = per_cnt <= 16'd1;
    assign conv_done   = (state == CONV) && (adc_valid || to_cnt == '0);
    assign timeout_evt = (state == CONV) && !adc_valid && to_cnt == '0;
    assign push        = (state == CONV) && adc_valid;
    assign pop         = m_valid && m_ready;
    assign full        = occ == (AW+1)'(DEPTH);
    assign do_write    = push && (!full || pop);
    assign ovf_evt     = push && full && !pop;
    assign m_valid     = occ != '0;
    assign m_data      = mem[rd_ptr];
    assign restart     = state == START;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (enable) state_nx = START;
            START: state_nx = CONV;
            CONV: begin
                if (conv_done) begin
                    if (!enable)         state_nx = IDLE;
                    else if (period_due) state_nx = START;
                    else                 state_nx = WAIT;
                end
            end
            WAIT:  if (period_due) state_nx = enable ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            per_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == START) begin
                per_cnt <= (sample_period > 16'd1) ? sample_period - 16'd1 : 16'd0;
                to_cnt  <= TW'(TIMEOUT - 1);
            end else begin
                if (per_cnt != 16'd0) per_cnt <= per_cnt - 16'd1;
                if (state == CONV && to_cnt != '0) to_cnt <= to_cnt - TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= adc_count;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_write, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // a new error event in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overflow    <= ovf_evt | (overflow & ~clr_err);
            timeout_err <= timeout_evt | (timeout_err & ~clr_err);
        end
    end
endmodule
